// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch buffer.
// The request register only ever has one outstanding address: IDLE or REQ.
package fetch_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } req_state_e;

endpackage

// File: rtl/ifb_queue.sv
// In-order circular buffer of {pc, instr, filled} entries.
// Allocation reserves a slot at grant time; responses fill slots oldest-first.
module ifb_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic            head_filled_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [CW-1:0]   alloc_cnt_o,
    output logic [CW-1:0]   unfilled_cnt_o
);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW-1:0]    fill_q;
    logic [CW-1:0]    alloc_cnt_q;
    logic [CW-1:0]    unfilled_q;

    logic pop_ok;
    logic fill_ok;

    // Guard against callers poking an empty head or a queue with nothing to fill.
    assign pop_ok  = pop_i && filled_q[head_q];
    assign fill_ok = fill_i && (unfilled_q != '0);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            fill_q      <= '0;
            alloc_cnt_q <= '0;
            unfilled_q  <= '0;
            filled_q    <= '0;
        end else begin
            if (pop_ok) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + PW'(1);
            end
            if (fill_ok) begin
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + PW'(1);
            end
            if (alloc_i) begin
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + PW'(1);
            end
            alloc_cnt_q <= alloc_cnt_q + CW'(alloc_i) - CW'(pop_ok);
            unfilled_q  <= unfilled_q + CW'(alloc_i) - CW'(fill_ok);
        end
    end

    // Payload storage needs no reset: validity lives entirely in filled_q.
    always_ff @(posedge clk) begin
        if (!rst && !clear_i) begin
            if (alloc_i) begin
                pc_q[tail_q] <= alloc_pc_i;
            end
            if (fill_ok) begin
                instr_q[fill_q] <= fill_data_i;
            end
        end
    end

    assign head_filled_o  = filled_q[head_q];
    assign head_pc_o      = pc_q[head_q];
    assign head_instr_o   = instr_q[head_q];
    assign alloc_cnt_o    = alloc_cnt_q;
    assign unfilled_cnt_o = unfilled_q;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch decoupling buffer: request register toward imem, in-order word queue toward decode.
// state | meaning
// IDLE  | no request on the memory port
// REQ   | imem_addr_o presented with imem_req_o, held until granted
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    req_state_e      state_q;
    logic [XLEN-1:0] addr_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   discard_d;

    logic            head_filled;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   unfilled_cnt;

    logic pending;
    logic granted;
    logic accept;
    logic alloc;
    logic fill;
    logic pop;
    logic rsp_consumed;

    assign pending = (state_q == REQ);
    assign granted = pending && imem_gnt_i;

    // The request in REQ already owns a slot, so it counts against capacity.
    assign pc_ready_o = !rst && !flush_i && (!pending || imem_gnt_i)
                        && ((alloc_cnt + CW'(pending)) < CW'(DEPTH));

    assign accept = pc_valid_i && pc_ready_o;
    assign alloc  = granted && !flush_i;
    assign fill   = imem_rvalid_i && (discard_q == '0) && (unfilled_cnt != '0) && !flush_i;
    assign pop    = instr_valid_o && instr_ready_i && !flush_i;

    // A response this cycle retires one in-flight request, stale or not.
    assign rsp_consumed = imem_rvalid_i && ((discard_q != '0) || (unfilled_cnt != '0));

    always_comb begin
        discard_d = discard_q;
        if (flush_i) begin
            discard_d = discard_q + unfilled_cnt + CW'(granted) - CW'(rsp_consumed);
        end else if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            discard_q <= '0;
        end else begin
            discard_q <= discard_d;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            addr_q  <= pc_i;
                            state_q <= REQ;
                        end
                    end
                    REQ: begin
                        if (imem_gnt_i) begin
                            if (accept) begin
                                addr_q <= pc_i;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    ifb_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (flush_i),
        .alloc_i        (alloc),
        .alloc_pc_i     (addr_q),
        .fill_i         (fill),
        .fill_data_i    (imem_rdata_i),
        .pop_i          (pop),
        .head_filled_o  (head_filled),
        .head_pc_o      (head_pc),
        .head_instr_o   (head_instr),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    assign imem_req_o    = pending;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = head_filled;
    // An empty head shows a NOP at PC 0 so stale payload never leaks to decode.
    assign instr_o       = head_filled ? head_instr : XLEN'(NOP);
    assign instr_pc_o    = head_filled ? head_pc : '0;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed vector table, corner-case sequences,
// then random traffic against an epoch-based memory/queue reference model.
module tb_instr_fetch_buffer;
    import fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_i;
    logic            pc_valid_i;
    logic            pc_ready_o;
    logic            flush_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_ready_i;

    always #5 clk = ~clk;

    instr_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic pv, input logic [31:0] pcv, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic fl, input logic rs);
        @(negedge clk);
        pc_valid_i    = pv;
        pc_i          = pcv;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        instr_ready_i = rdy;
        flush_i       = fl;
        rst           = rs;
        #1;
    endtask

    function automatic logic [98:0] outs();
        return {pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_pc_o, instr_o};
    endfunction

    task automatic exp_head(input string name, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        check(name, {instr_valid_o, instr_pc_o, instr_o}, {v, pc, ins});
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        e_pr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl [7];

    // Reference model state for the random phase.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          tag;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    mreq_t       mem_q [$];
    exp_t        exp_q [$];
    logic [31:0] acc_q [$];
    int          epoch      = 0;
    int          cyc_n      = 0;
    logic [31:0] next_pc    = 32'h0;
    logic        prev_stall = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    task automatic rand_cycle(input bit drain);
        logic        pv, g, rv, rdy, fl, rs;
        logic [31:0] rd;
        mreq_t       r;
        exp_t        e;
        int          live;
        pv  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
        g   = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
        rdy = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
        fl  = drain ? 1'b0 : ($urandom_range(0, 29) == 0);
        rs  = drain ? 1'b0 : ($urandom_range(0, 399) == 0);
        rv  = 1'b0;
        rd  = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc_n && (drain || $urandom_range(0, 3) != 0)) begin
            rv = 1'b1;
            rd = mem_q[0].data;
        end
        cyc(pv, next_pc, g, rv, rd, rdy, fl, rs);
        if (rs) begin
            check("rand_rst_ready", pc_ready_o, 0);
            mem_q.delete();
            acc_q.delete();
            exp_q.delete();
            epoch++;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
            cyc_n++;
            return;
        end
        if (prev_stall)
            check("rand_stall_hold", {imem_req_o, imem_addr_o}, {1'b1, prev_addr});
        if (prev_flush)
            check("rand_flush_req", imem_req_o, 0);
        if (fl)
            check("rand_flush_ready", pc_ready_o, 0);
        if (imem_req_o && g) begin
            check("rand_grant_pending", acc_q.size(), 1);
            if (acc_q.size() > 0)
                check("rand_grant_addr", imem_addr_o, acc_q.pop_front());
            r.addr = imem_addr_o;
            r.data = $urandom;
            r.tag  = fl ? -1 : epoch;
            r.due  = cyc_n + $urandom_range(1, 3);
            mem_q.push_back(r);
        end
        if (rv) begin
            r = mem_q.pop_front();
            if (r.tag == epoch && !fl) begin
                e.pc  = r.addr;
                e.ins = r.data;
                exp_q.push_back(e);
            end
        end
        if (instr_valid_o && rdy && !fl) begin
            check("rand_pop_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rand_pop_word", {instr_pc_o, instr_o}, {e.pc, e.ins});
            end
        end
        if (pv && pc_ready_o) begin
            acc_q.push_back(next_pc);
            next_pc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : next_pc + 32'd4;
        end
        live = exp_q.size() + acc_q.size();
        foreach (mem_q[i]) if (mem_q[i].tag == epoch) live++;
        check("rand_occupancy", live <= DEPTH, 1);
        if (fl) begin
            exp_q.delete();
            acc_q.delete();
            epoch++;
        end
        prev_stall = imem_req_o && !g && !fl;
        prev_addr  = imem_addr_o;
        prev_flush = fl;
        cyc_n++;
    endtask

    initial begin
        logic [31:0] bp_pc [4];
        logic [31:0] bp_d  [4];

        rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;

        //            pv  pc     g  rv  rd      rdy  pr req addr   v  ipc    ins
        tbl[0] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP};
        tbl[1] = '{1'b1, 32'h4, 1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, NOP};
        tbl[2] = '{1'b1, 32'h8, 1'b1, 1'b1, 32'hA0, 1'b1, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, NOP};
        tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 32'hA0};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h4, 32'hA1};
        tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h8, 1'b1, 32'h8, 32'hA2};
        tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0, NOP};

        // Reset values
        do_reset();
        check("reset_outputs", outs(), {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP});

        // Zero-wait stream
        foreach (tbl[i]) begin
            cyc(tbl[i].pv, tbl[i].pc, tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].rdy, 1'b0, 1'b0);
            check($sformatf("stream_c%0d", i), outs(),
                  {tbl[i].e_pr, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v, tbl[i].e_ipc, tbl[i].e_ins});
        end

        // Grant stall
        do_reset();
        cyc(1, 32'h40, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0);
            check($sformatf("stall_c%0d", i), {imem_req_o, imem_addr_o, pc_ready_o, instr_valid_o},
                  {1'b1, 32'h40, 1'b0, 1'b0});
        end
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        check("stall_grant", {imem_req_o, imem_addr_o}, {1'b1, 32'h40});
        cyc(0, 0, 0, 1, 32'hB0, 1, 0, 0);
        check("stall_req_drop", imem_req_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("stall_word", 1, 32'h40, 32'hB0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("stall_empty", 0, 32'h0, NOP);

        // Backpressure / full
        do_reset();
        bp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
        bp_d  = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        cyc(1, 32'h0, 0, 0, 0, 0, 0, 0);
        check("bp_ready0", pc_ready_o, 1);
        cyc(1, 32'h4, 1, 0, 0, 0, 0, 0);
        check("bp_ready1", pc_ready_o, 1);
        cyc(1, 32'h8, 1, 1, 32'hD0, 0, 0, 0);
        check("bp_ready2", pc_ready_o, 1);
        cyc(1, 32'hC, 1, 1, 32'hD1, 0, 0, 0);
        check("bp_ready3", pc_ready_o, 1);
        cyc(1, 32'h10, 1, 1, 32'hD2, 0, 0, 0);
        check("bp_full_grant4", pc_ready_o, 0);
        cyc(1, 32'h10, 0, 1, 32'hD3, 0, 0, 0);
        check("bp_full_idle", {pc_ready_o, instr_valid_o, instr_pc_o, instr_o}, {1'b0, 1'b1, 32'h0, 32'hD0});
        cyc(1, 32'h10, 0, 0, 0, 1, 0, 0);
        check("bp_full_pop_cycle", pc_ready_o, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("bp_reraise", pc_ready_o, 1);
        for (int i = 1; i < 4; i++) begin
            if (i > 1) cyc(0, 0, 0, 0, 0, 1, 0, 0);
            else       begin instr_ready_i = 1'b1; #1; end
            exp_head($sformatf("bp_order%0d", i), 1, bp_pc[i], bp_d[i]);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("bp_drained", 0, 32'h0, NOP);

        // Flush with two responses in flight
        do_reset();
        cyc(1, 32'h10, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h14, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        check("fl2_ready", pc_ready_o, 0);
        cyc(0, 0, 0, 1, 32'hDEAD1, 1, 0, 0);
        check("fl2_drop1", {imem_req_o, instr_valid_o}, 2'b00);
        cyc(0, 0, 0, 1, 32'hDEAD2, 1, 0, 0);
        check("fl2_drop2", instr_valid_o, 0);
        cyc(1, 32'h100, 0, 0, 0, 1, 0, 0);
        check("fl2_accept", {pc_ready_o, instr_valid_o}, 2'b10);
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        check("fl2_req", {imem_req_o, imem_addr_o, instr_valid_o}, {1'b1, 32'h100, 1'b0});
        cyc(0, 0, 0, 1, 32'hC0, 1, 0, 0);
        check("fl2_wait", instr_valid_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("fl2_new_word", 1, 32'h100, 32'hC0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("fl2_after", 0, 32'h0, NOP);

        // Flush coincident with grant and response
        do_reset();
        cyc(1, 32'h20, 0, 0, 0, 1, 0, 0);
        cyc(1, 32'h24, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 32'hBAD0, 1, 1, 0);
        cyc(0, 0, 0, 1, 32'hBAD1, 1, 0, 0);
        check("flc_drop", {imem_req_o, instr_valid_o}, 2'b00);
        cyc(1, 32'h30, 0, 0, 0, 1, 0, 0);
        check("flc_accept", {pc_ready_o, instr_valid_o}, 2'b10);
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        check("flc_req", {imem_req_o, instr_valid_o}, 2'b10);
        cyc(0, 0, 0, 1, 32'hC1, 1, 0, 0);
        check("flc_wait", instr_valid_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("flc_word", 1, 32'h30, 32'hC1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("flc_after", 0, 32'h0, NOP);

        // Reset mid-stream with three entries queued
        do_reset();
        cyc(1, 32'h0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h4, 1, 0, 0, 0, 0, 0);
        cyc(1, 32'h8, 1, 1, 32'hE0, 0, 0, 0);
        cyc(0, 0, 1, 1, 32'hE1, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'hE2, 0, 0, 0);
        exp_head("rst_pre_head", 1, 32'h0, 32'hE0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_mid_outputs", outs(), {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, NOP});
        cyc(1, 32'h0, 0, 0, 0, 1, 0, 0);
        check("rst_after_ready", pc_ready_o, 1);
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 32'hE9, 1, 0, 0);
        check("rst_after_wait", instr_valid_o, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        exp_head("rst_after_word", 1, 32'h0, 32'hE9);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0 && acc_q.size() == 0 && !instr_valid_o) break;
            rand_cycle(1'b1);
        end
        check("drain_empty", {exp_q.size() == 0, mem_q.size() == 0, acc_q.size() == 0, instr_valid_o},
              4'b1110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
